// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage (mult/multu/div/divu, mthi/mtlo).
// Define MDU_MADD_EN to add madd/maddu (MDOp 6/7) accumulating into {HI,LO}.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        HiLoSel,
    output logic        Busy,
    output logic [31:0] Out
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic        state;
    logic [31:0] cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] result;
    logic        commit;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        div_zero;
    logic        is_mul;
    logic        is_div;
    logic [63:0] next_result;

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    always_comb begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u   = {32'b0, A} * {32'b0, B};
        div_zero = (B == '0);
        a_mag    = A[31] ? -A : A;
        b_mag    = B[31] ? -B : B;
        q_mag    = div_zero ? '0 : a_mag / b_mag;
        r_mag    = div_zero ? '0 : a_mag % b_mag;
        q_u      = div_zero ? '0 : A / B;
        r_u      = div_zero ? '0 : A % B;
        q_s      = (A[31] ^ B[31]) ? -q_mag : q_mag;
        r_s      = A[31] ? -r_mag : r_mag;
    end

    always_comb begin
        is_mul      = 1'b0;
        is_div      = 1'b0;
        next_result = '0;
        case (MDOp)
            3'd0: begin is_mul = 1'b1; next_result = prod_s; end
            3'd1: begin is_mul = 1'b1; next_result = prod_u; end
            3'd2: begin is_div = 1'b1; next_result = {r_s, q_s}; end
            3'd3: begin is_div = 1'b1; next_result = {r_u, q_u}; end
`ifdef MDU_MADD_EN
            3'd6: begin is_mul = 1'b1; next_result = {hi, lo} + prod_s; end
            3'd7: begin is_mul = 1'b1; next_result = {hi, lo} + prod_u; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            commit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (MDOp == 3'd4) hi <= A;
                        if (MDOp == 3'd5) lo <= A;
                        if (is_mul || is_div) begin
                            result <= next_result;
                            commit <= !(is_div && div_zero);
                            cnt    <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                            state  <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (cnt == 32'd1) begin
                        if (commit) {hi, lo} <= result;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
            endcase
        end
    end

    assign Busy = (state == S_RUN);
    assign Out  = HiLoSel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and Busy length, monitor pops and compares.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic [2:0]  MDOp;
    logic        HiLoSel = 1'b0;
    logic        Busy;
    logic [31:0] Out;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Start(Start), .MDOp(MDOp),
        .HiLoSel(HiLoSel), .Busy(Busy), .Out(Out)
    );

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        probe = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        longint          sa, sb_;
        longint unsigned ua, ub;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        cyc = 0;
        case (op)
            3'd0: begin {m_hi, m_lo} = sa * sb_; cyc = MC; end
            3'd1: begin {m_hi, m_lo} = ua * ub; cyc = MC; end
            3'd2: begin
                cyc = DC;
                if (b != 0) begin m_lo = 32'(sa / sb_); m_hi = 32'(sa % sb_); end
            end
            3'd3: begin
                cyc = DC;
                if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MDU_MADD_EN
            3'd6: begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb_); cyc = MC; end
            3'd7: begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(ua * ub); cyc = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: Busy still %b after %0d cycles, expected 0", Busy, n);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input bit push);
        int cyc;
        wait_idle();
        Start = 1'b1; MDOp = op; A = a; B = b;
        cyc = 0;
        if (push) begin
            model(op, a, b, cyc);
            sb.push_back('{cyc, m_hi, m_lo, name});
        end
        @(negedge clk);
        Start = 1'b0;
        if (push && cyc == 0) begin
            probe = 1'b1;
            @(negedge clk);
            probe = 1'b0;
        end
    endtask

    task automatic poke(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: completion is the first Busy=0 cycle after a run, or a probe after a non-busy op.
    initial begin
        int          run = 0;
        exp_t        e;
        logic [31:0] lo_act, hi_act;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1) begin
                run = 0;
            end else if (Busy === 1'b1) begin
                run++;
            end else if (run > 0 || probe) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: busy run %0d, expected no pending op", run);
                end else begin
                    e = sb.pop_front();
                    HiLoSel = 1'b0;
                    #1 lo_act = Out;
                    HiLoSel = 1'b1;
                    #1 hi_act = Out;
                    HiLoSel = 1'b0;
                    check32({e.name, "_busy_cycles"}, 32'(run), 32'(e.cyc));
                    check32({e.name, "_hi"}, hi_act, e.hi);
                    check32({e.name, "_lo"}, lo_act, e.lo);
                end
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{0, 32'h0, 32'h0, "reset_init"});
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg", 1'b1);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, "multu", 1'b1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b1);
        issue(3'd3, 32'd7, 32'd2, "divu", 1'b1);
        issue(3'd4, 32'h11, 32'd0, "mthi", 1'b1);
        issue(3'd5, 32'h22, 32'd0, "mtlo", 1'b1);
        issue(3'd2, 32'd5, 32'd0, "div_zero", 1'b1);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, "mtlo_deadbeef", 1'b1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);

        // Starts during a run must be ignored whatever the op.
        issue(3'd0, 32'd7, 32'd9, "mult_ignore", 1'b1);
        poke(3'd4, 32'd1, 32'd0);
        poke(3'd2, 32'd100, 32'd3);
        poke(3'd5, 32'hABCD_0000, 32'd0);

        issue(3'd4, 32'h0, 32'd0, "madd_pre_hi", 1'b1);
        issue(3'd5, 32'hFFFF_FFFF, 32'd0, "madd_pre_lo", 1'b1);
        issue(3'd6, 32'd1, 32'd1, "madd", 1'b1);
        issue(3'd7, 32'hFFFF_FFFF, 32'd2, "maddu", 1'b1);

        // Reset in the middle of a divide aborts it and clears HI/LO.
        issue(3'd2, 32'd100, 32'd7, "", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("rst_busy", {31'b0, Busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        sb.push_back('{0, 32'h0, 32'h0, "rst_mid_div"});
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, $sformatf("rand%0d_op%0d", i, op), 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check32("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the 5-stage MIPS pipeline, beside the ALU.
- Executes mult/multu/div/divu into HI/LO and handles mthi/mtlo writes.
- Provides mfhi/mflo read data to the EX→MEM result path.
- Asserts Busy so the hazard/stall controller holds ID while any mult/div/mfhi/mflo/mthi/mtlo sits in ID.

Parameters:
- MULT_CYCLES, 5, Busy-high cycles for mult/multu (≥1).
- DIV_CYCLES, 10, Busy-high cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- A  input  32  forwarded rs value (Mux_rsE).
- B  input  32  forwarded rt value (Mux_rtE).
- Start  input  1  one-cycle request from EX_Control; qualifies MDOp.
- MDOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu (6/7 only with the optional feature).
- HiLoSel  input  1  read select: 0 LO, 1 HI.
- Busy  output  1  operation in progress.
- Out  output  32  HiLoSel ? HI : LO, combinational.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: HI=0, LO=0, Busy=0, counter=0, latched operands=0.
  - Out=0 the cycle after reset.
  - rst during an operation aborts it; no HI/LO write.
- Internal state: IDLE / RUN, a counter, latched op, and latched 64-bit result.
- IDLE with Start=1 at edge T:
  - mult/multu/div/divu: compute the result from A/B into the result register and load the counter (MULT_CYCLES or DIV_CYCLES). Busy=1 from T+1. Go to RUN.
  - mthi: HI←A at T. mtlo: LO←A at T. Busy stays 0; no state change.
  - Undefined MDOp: ignored.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==1: HI/LO←result, Busy←0, return to IDLE.
  - Busy is therefore high for exactly N cycles.
  - New HI/LO values are visible on Out in the first cycle Busy=0.
- Start while Busy=1: ignored, whatever the MDOp; HI/LO are not disturbed. The hazard unit guarantees this never happens; the bench checks the ignore rule anyway.
- Back-to-back: Start may be asserted in the first cycle Busy=0. It then reads the just-written HI/LO (needed for madd).
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}.
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B==0): runs the full DIV_CYCLES; HI/LO keep their previous values.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- During RUN, Out shows the old HI/LO; reads are stalled upstream.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MDOp 6 (madd): {HI,LO}←{HI,LO}+signed(A×B), 64-bit wrap.
  - MDOp 7 (maddu): unsigned product, same accumulate.
  - Both take MULT_CYCLES.
  - The accumulate uses the HI/LO values at the Start edge.
- Not defined: MDOp 6/7 are treated as undefined and ignored (no Busy, HI/LO unchanged).

Test Plan:
- Reset:
  - Assert rst for 2 cycles mid-div → Busy=0 next cycle, HI=LO=0, Out=0 for both HiLoSel values.
- mult signed:
  - A=0xFFFFFFFE (−2), B=3 → Busy high exactly 5 cycles.
  - Then LO=0xFFFFFFFA, HI=0xFFFFFFFF.
  - Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div signed:
  - A=−7 (0xFFFFFFF9), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 → LO=3, HI=1.
- Divide by zero:
  - Preload HI=0x11, LO=0x22 via mthi/mtlo, then div A=5, B=0.
  - Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- mthi/mtlo and ignore rule:
  - mtlo A=0xDEADBEEF → Out (HiLoSel=0)=0xDEADBEEF the next cycle, Busy never set.
  - Start mthi A=1 in cycle 2 of a running mult → HI ends equal to the mult result, not 1.
- madd (MDU_MADD_EN defined):
  - HI=0, LO=0xFFFFFFFF, madd A=1, B=1 → HI=1, LO=0 after 5 cycles.
  - Without the macro the same Start → HI/LO unchanged, Busy stays 0.
